qdma_stm_c2h_gen: RTL and testbench

- Self-timed C2H streaming traffic generator: the transmit-side counterpart of the H2C stream receive path.
- Produces C2H payload packets with a deterministic dword pattern toward the QDMA C2H payload port. One completion entry follows each packet on the completion port.
- Driven by a small config interface (start pulse plus qid/length/count/seed) from the example-design register block. Used for C2H-only bandwidth tests and driver bring-up without H2C traffic.

---
 rtl/qdma_stm_c2h_gen_if.sv | 39 +++
 rtl/qdma_stm_c2h_gen.sv | 204 ++++++++++++++++++++
 tb/tb_qdma_stm_c2h_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/qdma_stm_c2h_gen_if.sv
// C2H stream bundle between the traffic generator and the QDMA C2H ports:
// payload beats plus one completion entry per packet.
interface qdma_stm_c2h_gen_if #(
  parameter int unsigned MAX_DATA_WIDTH = 512,
  parameter int unsigned QID_BITS       = 11,
  parameter int unsigned LEN_BITS       = 16
);
  localparam int unsigned BYTES    = MAX_DATA_WIDTH / 8;
  localparam int unsigned MTY_BITS = $clog2(BYTES);

  logic [MAX_DATA_WIDTH-1:0] out_axis_pld_tdata;
  logic [QID_BITS-1:0]       out_axis_pld_qid;
  logic [LEN_BITS-1:0]       out_axis_pld_len;
  logic [MTY_BITS-1:0]       out_axis_pld_mty;
  logic                      out_axis_pld_tlast;
  logic                      out_axis_pld_tvalid;
  logic                      out_axis_pld_tready;

  logic [127:0]              out_axis_cmp_data;
  logic [QID_BITS-1:0]       out_axis_cmp_qid;
  logic                      out_axis_cmp_tvalid;
  logic                      out_axis_cmp_tready;

  modport master (
    output out_axis_pld_tdata, out_axis_pld_qid, out_axis_pld_len, out_axis_pld_mty,
    output out_axis_pld_tlast, out_axis_pld_tvalid,
    input  out_axis_pld_tready,
    output out_axis_cmp_data, out_axis_cmp_qid, out_axis_cmp_tvalid,
    input  out_axis_cmp_tready
  );

  modport slave (
    input  out_axis_pld_tdata, out_axis_pld_qid, out_axis_pld_len, out_axis_pld_mty,
    input  out_axis_pld_tlast, out_axis_pld_tvalid,
    output out_axis_pld_tready,
    input  out_axis_cmp_data, out_axis_cmp_qid, out_axis_cmp_tvalid,
    output out_axis_cmp_tready
  );
endinterface

// File: rtl/qdma_stm_c2h_gen.sv
// Self-timed C2H streaming traffic generator. On a start pulse it emits
// cfg_num_pkt packets of cfg_len bytes with an incrementing dword pattern,
// each followed by one completion entry, then pulses done.
module qdma_stm_c2h_gen #(
  parameter int unsigned MAX_DATA_WIDTH = 512,
  parameter int unsigned QID_BITS       = 11,
  parameter int unsigned LEN_BITS       = 16,
  parameter int          TCQ            = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [QID_BITS-1:0] cfg_qid,
  input  logic [LEN_BITS-1:0] cfg_len,
  input  logic [15:0]         cfg_num_pkt,
  input  logic [31:0]         cfg_seed,
  output logic                busy,
  output logic                done,
  qdma_stm_c2h_gen_if.master  axis
);
  localparam int unsigned BYTES    = MAX_DATA_WIDTH / 8;
  localparam int unsigned LANES    = MAX_DATA_WIDTH / 32;
  localparam int unsigned MTY_BITS = $clog2(BYTES);
  localparam logic [31:0]         CNT_STEP = 32'(LANES);
  localparam logic [LEN_BITS-1:0] BYTES_L  = LEN_BITS'(BYTES);

  // Registered assignments carry no clock-to-q delay; TCQ is kept only so
  // existing instantiations that override it still elaborate.
  if ((MAX_DATA_WIDTH % 32) != 0 || TCQ < 0) begin : g_param_chk
    $error("qdma_stm_c2h_gen: MAX_DATA_WIDTH must be a multiple of 32 and TCQ non-negative");
  end

  typedef enum logic [1:0] {S_IDLE, S_PLD, S_CMP, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [QID_BITS-1:0]       qid_q, qid_d;
  logic [LEN_BITS-1:0]       len_q, len_d;
  logic [15:0]               num_q, num_d;
  logic [15:0]               pkt_idx_q, pkt_idx_d;
  logic [31:0]               cnt_q, cnt_d;
  logic [31:0]               first_q, first_d;
  logic [LEN_BITS-1:0]       rem_q, rem_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [MAX_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [MTY_BITS-1:0]       mty_q, mty_d;
  logic                      tlast_q, tlast_d;
  logic                      tvalid_q, tvalid_d;
  logic [127:0]              cmp_data_q, cmp_data_d;
  logic                      cmp_tvalid_q, cmp_tvalid_d;

  logic                      load_beat;
  logic [31:0]               beat_lane0;
  logic [LEN_BITS-1:0]       beat_rem;

  // Beat image: lane k = lane0 + k, bytes at or beyond the remaining count zeroed.
  function automatic logic [MAX_DATA_WIDTH-1:0] beat_data(input logic [31:0] lane0,
                                                          input logic [LEN_BITS-1:0] rem);
    logic [MAX_DATA_WIDTH-1:0] d;
    d = '0;
    for (int unsigned k = 0; k < LANES; k++) d[32*k +: 32] = lane0 + k;
    for (int unsigned b = 0; b < BYTES; b++) if (b >= 32'(rem)) d[8*b +: 8] = '0;
    return d;
  endfunction

  // State and output registers; everything visible on the ports comes from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      qid_q        <= '0;
      len_q        <= '0;
      num_q        <= '0;
      pkt_idx_q    <= '0;
      cnt_q        <= '0;
      first_q      <= '0;
      rem_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tdata_q      <= '0;
      mty_q        <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      cmp_data_q   <= '0;
      cmp_tvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      qid_q        <= qid_d;
      len_q        <= len_d;
      num_q        <= num_d;
      pkt_idx_q    <= pkt_idx_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      rem_q        <= rem_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tdata_q      <= tdata_d;
      mty_q        <= mty_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
      cmp_data_q   <= cmp_data_d;
      cmp_tvalid_q <= cmp_tvalid_d;
    end
  end

  // Next-state and next-output logic. rem tracks bytes left in the packet
  // starting at the presented beat, so last/mty need no division by BYTES.
  always_comb begin
    state_d      = state_q;
    qid_d        = qid_q;
    len_d        = len_q;
    num_d        = num_q;
    pkt_idx_d    = pkt_idx_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    rem_d        = rem_q;
    tdata_d      = tdata_q;
    mty_d        = mty_q;
    tlast_d      = tlast_q;
    tvalid_d     = tvalid_q;
    cmp_data_d   = cmp_data_q;
    cmp_tvalid_d = cmp_tvalid_q;
    load_beat    = 1'b0;
    beat_lane0   = cnt_q;
    beat_rem     = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          qid_d     = cfg_qid;
          len_d     = cfg_len;
          num_d     = cfg_num_pkt;
          cnt_d     = cfg_seed;
          first_d   = cfg_seed;
          rem_d     = cfg_len;
          pkt_idx_d = '0;
          if (cfg_len == '0 || cfg_num_pkt == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_PLD;
            load_beat  = 1'b1;
            beat_lane0 = cfg_seed;
            beat_rem   = cfg_len;
          end
        end
      end
      S_PLD: begin
        if (tvalid_q && axis.out_axis_pld_tready) begin
          cnt_d = cnt_q + CNT_STEP;
          rem_d = rem_q - BYTES_L;
          if (tlast_q) begin
            state_d      = S_CMP;
            tvalid_d     = 1'b0;
            cmp_tvalid_d = 1'b1;
            cmp_data_d   = {64'd0, first_q, pkt_idx_q, 16'(len_q)};
          end else begin
            load_beat  = 1'b1;
            beat_lane0 = cnt_q + CNT_STEP;
            beat_rem   = rem_q - BYTES_L;
          end
        end
      end
      S_CMP: begin
        if (cmp_tvalid_q && axis.out_axis_cmp_tready) begin
          cmp_tvalid_d = 1'b0;
          pkt_idx_d    = pkt_idx_q + 16'd1;
          if (pkt_idx_q + 16'd1 == num_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_PLD;
            rem_d      = len_q;
            first_d    = cnt_q;
            load_beat  = 1'b1;
            beat_lane0 = cnt_q;
            beat_rem   = len_q;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load_beat) begin
      tvalid_d = 1'b1;
      tdata_d  = beat_data(beat_lane0, beat_rem);
      tlast_d  = (beat_rem <= BYTES_L);
      mty_d    = (beat_rem <= BYTES_L) ? MTY_BITS'(BYTES_L - beat_rem) : '0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  assign busy                     = busy_q;
  assign done                     = done_q;
  assign axis.out_axis_pld_tdata  = tdata_q;
  assign axis.out_axis_pld_qid    = qid_q;
  assign axis.out_axis_pld_len    = len_q;
  assign axis.out_axis_pld_mty    = mty_q;
  assign axis.out_axis_pld_tlast  = tlast_q;
  assign axis.out_axis_pld_tvalid = tvalid_q;
  assign axis.out_axis_cmp_data   = cmp_data_q;
  assign axis.out_axis_cmp_qid    = qid_q;
  assign axis.out_axis_cmp_tvalid = cmp_tvalid_q;
endmodule

// File: tb/tb_qdma_stm_c2h_gen.sv
// Bench for qdma_stm_c2h_gen: directed and randomized runs scored against a
// byte-level model of the expected packet stream and completion entries.
module tb_qdma_stm_c2h_gen;
  localparam int unsigned W     = 512;
  localparam int unsigned QB    = 11;
  localparam int unsigned LB    = 16;
  localparam int unsigned BYTES = W / 8;
  localparam int unsigned LANES = W / 32;
  localparam int unsigned NOPOKE = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [QB-1:0] cfg_qid = '0;
  logic [LB-1:0] cfg_len = '0;
  logic [15:0]   cfg_num_pkt = '0;
  logic [31:0]   cfg_seed = '0;
  logic          busy, done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  qdma_stm_c2h_gen_if #(.MAX_DATA_WIDTH(W), .QID_BITS(QB), .LEN_BITS(LB)) axis ();

  qdma_stm_c2h_gen #(.MAX_DATA_WIDTH(W), .QID_BITS(QB), .LEN_BITS(LB), .TCQ(0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_qid(cfg_qid),
    .cfg_len(cfg_len), .cfg_num_pkt(cfg_num_pkt), .cfg_seed(cfg_seed),
    .busy(busy), .done(done), .axis(axis.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat built byte by byte: global beat number n starts at seed+16n,
  // byte i holds byte (i%4) of dword (start + i/4); bytes past len are zero.
  function automatic logic [W-1:0] exp_beat(input logic [31:0] seed, input int unsigned len,
                                            input int unsigned n, input int unsigned b,
                                            input int unsigned nb);
    logic [W-1:0] d;
    logic [31:0]  base;
    logic [31:0]  dw;
    int unsigned  valid;
    base  = seed + 32'(n * LANES);
    valid = (b == nb - 1) ? len - (nb - 1) * BYTES : BYTES;
    d = '0;
    for (int unsigned i = 0; i < valid; i++) begin
      dw = (base + 32'(i / 4)) >> (8 * (i % 4));
      d[8*i +: 8] = dw[7:0];
    end
    return d;
  endfunction

  task automatic start_run(input logic [QB-1:0] q, input int unsigned len, input int unsigned num,
                           input logic [31:0] seed);
    cfg_qid = q; cfg_len = LB'(len); cfg_num_pkt = 16'(num); cfg_seed = seed;
    cfg_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // One full run: thr is the percentage of cycles each ready is withheld,
  // poke is the cycle at which a conflicting start is pulsed while busy.
  task automatic run_check(input logic [QB-1:0] q, input int unsigned len, input int unsigned num,
                           input logic [31:0] seed, input int unsigned thr, input int unsigned poke);
    int unsigned  nb, total, beats, cmps, cyc, done_cyc, b;
    bit           fin, saw_valid, zero, prdy, crdy, pstall, cstall;
    logic [W-1:0] sv_data;
    logic [127:0] sv_cmp;
    logic [5:0]   sv_mty;
    bit           sv_last;
    nb = (len + BYTES - 1) / BYTES;
    zero = (len == 0) || (num == 0);
    total = zero ? 0 : nb * num;
    beats = 0; cmps = 0; cyc = 0; done_cyc = NOPOKE;
    fin = 0; saw_valid = 0; pstall = 0; cstall = 0;
    sv_data = '0; sv_cmp = '0; sv_mty = '0; sv_last = 0;
    axis.out_axis_pld_tready = 1'b0;
    axis.out_axis_cmp_tready = 1'b0;
    start_run(q, len, num, seed);
    chk("busy_after_start", W'(busy), W'(1'b1));
    if (!zero) chk("start_latency_tvalid", W'(axis.out_axis_pld_tvalid), W'(1'b1));
    while (!fin && cyc < 5000) begin
      chk("pld_cmp_exclusive", W'(axis.out_axis_pld_tvalid & axis.out_axis_cmp_tvalid), W'(1'b0));
      if (pstall) begin
        chk("hold_pld_tvalid", W'(axis.out_axis_pld_tvalid), W'(1'b1));
        chk("hold_pld_tdata", axis.out_axis_pld_tdata, sv_data);
        chk("hold_pld_mty_last", W'({axis.out_axis_pld_mty, axis.out_axis_pld_tlast}), W'({sv_mty, sv_last}));
      end
      if (cstall) begin
        chk("hold_cmp_tvalid", W'(axis.out_axis_cmp_tvalid), W'(1'b1));
        chk("hold_cmp_data", W'(axis.out_axis_cmp_data), W'(sv_cmp));
      end
      if (cyc == poke) begin
        cfg_qid = ~q; cfg_len = LB'(len + 7); cfg_num_pkt = 16'(num + 3); cfg_seed = ~seed;
        cfg_start = 1'b1;
      end else begin
        cfg_start = 1'b0;
      end
      prdy = ($urandom_range(99) >= thr);
      crdy = ($urandom_range(99) >= thr);
      axis.out_axis_pld_tready = prdy;
      axis.out_axis_cmp_tready = crdy;
      if (axis.out_axis_pld_tvalid || axis.out_axis_cmp_tvalid) saw_valid = 1;
      if (axis.out_axis_pld_tvalid && prdy) begin
        b = beats % nb;
        chk("pld_tdata", axis.out_axis_pld_tdata, exp_beat(seed, len, beats, b, nb));
        chk("pld_mty", W'(axis.out_axis_pld_mty), W'((b == nb - 1) ? nb * BYTES - len : 0));
        chk("pld_tlast", W'(axis.out_axis_pld_tlast), W'(b == nb - 1));
        chk("pld_qid", W'(axis.out_axis_pld_qid), W'(q));
        chk("pld_len", W'(axis.out_axis_pld_len), W'(len));
        beats++;
      end
      if (axis.out_axis_cmp_tvalid && crdy) begin
        chk("cmp_order", W'(beats), W'((cmps + 1) * nb));
        chk("cmp_data", W'(axis.out_axis_cmp_data),
            W'({64'd0, seed + 32'(cmps * nb * LANES), 16'(cmps), 16'(len)}));
        chk("cmp_qid", W'(axis.out_axis_cmp_qid), W'(q));
        cmps++;
      end
      pstall  = axis.out_axis_pld_tvalid && !prdy;
      cstall  = axis.out_axis_cmp_tvalid && !crdy;
      sv_data = axis.out_axis_pld_tdata;
      sv_mty  = axis.out_axis_pld_mty;
      sv_last = axis.out_axis_pld_tlast;
      sv_cmp  = axis.out_axis_cmp_data;
      if (done) begin
        fin = 1; done_cyc = cyc;
        chk("busy_low_with_done", W'(busy), W'(1'b0));
        chk("beat_count", W'(beats), W'(total));
        chk("cmp_count", W'(cmps), W'(zero ? 0 : num));
      end
      @(negedge clk);
      cyc++;
    end
    cfg_start = 1'b0;
    chk("done_seen", W'(fin), W'(1'b1));
    chk("done_one_cycle", W'(done), W'(1'b0));
    if (zero) begin
      chk("zero_done_latency", W'(done_cyc), W'(1));
      chk("zero_no_traffic", W'(saw_valid), W'(1'b0));
    end
  endtask

  initial begin
    bit any_out;
    axis.out_axis_pld_tready = 1'b0;
    axis.out_axis_cmp_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", W'({busy, done, axis.out_axis_pld_tvalid, axis.out_axis_cmp_tvalid,
                             axis.out_axis_pld_qid, axis.out_axis_pld_len}), W'(0));
    chk("reset_tdata", axis.out_axis_pld_tdata, W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_check(11'd5, 64, 1, 32'h0, 0, NOPOKE);
    run_check(11'($urandom), 100, 2, 32'h1000, 0, NOPOKE);
    run_check(11'($urandom), 300, 8, $urandom, 50, NOPOKE);
    run_check(11'($urandom), 0, 3, $urandom, 0, NOPOKE);
    run_check(11'($urandom), 100, 0, $urandom, 0, NOPOKE);
    run_check(11'd7, 200, 3, $urandom, 20, 2);

    // Reset in the middle of a packet abandons the run.
    axis.out_axis_pld_tready = 1'b1;
    start_run(11'd3, 300, 4, $urandom);
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", W'(busy), W'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", W'({busy, done, axis.out_axis_pld_tvalid, axis.out_axis_cmp_tvalid,
                                   axis.out_axis_pld_qid, axis.out_axis_pld_len}), W'(0));
    chk("async_reset_tdata", axis.out_axis_pld_tdata, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    any_out = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy || axis.out_axis_pld_tvalid || axis.out_axis_cmp_tvalid) any_out = 1;
    end
    chk("quiet_after_reset", W'(any_out), W'(1'b0));
    run_check(11'd9, 130, 2, $urandom, 30, NOPOKE);

    run_check(11'd1, 64, 1, 32'hFFFF_FFF8, 0, NOPOKE);
    for (int r = 0; r < 4; r++)
      run_check(11'($urandom), $urandom_range(400, 1), $urandom_range(4, 1), $urandom, 40, NOPOKE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
